// File: rtl/encoder_decoder.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus an independent hard-decision
// register-exchange Viterbi decoder. Define ENCODER_DECODER_PM_NORM_EN for metric normalization.
module encoder_decoder #(
  parameter int unsigned TB_LEN = 8,
  parameter int unsigned PM_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out,
  output logic       dec_valid_o
);

  localparam int unsigned CntW = $clog2(TB_LEN + 1);
  localparam logic [PM_W:0] PmMax = {1'b0, {PM_W{1'b1}}};

  // ---------------- Encoder ----------------
  logic [1:0] enc_state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_q <= 2'b00;
      enc_d_out   <= 2'b00;
      enc_valid_o <= 1'b0;
    end else if (enc_enable_i) begin
      enc_d_out   <= {enc_d_in ^ enc_state_q[1] ^ enc_state_q[0], enc_d_in ^ enc_state_q[0]};
      enc_state_q <= {enc_d_in, enc_state_q[1]};
      enc_valid_o <= 1'b1;
    end else begin
      enc_valid_o <= 1'b0;
    end
  end

  // ---------------- Decoder ----------------
  logic [PM_W-1:0]   pm_q     [4];
  logic [PM_W-1:0]   pm_d     [4];
  logic [TB_LEN-1:0] surv_q   [4];
  logic [TB_LEN-1:0] surv_new [4];
  logic [PM_W:0]     sum      [4];
  logic [3:0]        sel1;
  logic [1:0]        best;
  logic [PM_W:0]     min_sum;
  logic [CntW-1:0]   cnt_q;
  logic [CntW:0]     cnt_inc;
  logic              cnt_full;

  // Hamming distance between received symbol and the transition's expected output.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] st,
                                               input logic u);
    logic [1:0] x;
    x = rx ^ {u ^ st[1] ^ st[0], u ^ st[0]};
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W:0] add_metric(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, pm} + (PM_W + 1)'(bm);
`ifdef ENCODER_DECODER_PM_NORM_EN
    return s;
`else
    return (s > PmMax) ? PmMax : s;
`endif
  endfunction

  // Next state {u,a} is reached from predecessors {a,0} and {a,1}.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] Ns = 2'(g);
    localparam logic [1:0] P0 = {Ns[0], 1'b0};
    localparam logic [1:0] P1 = {Ns[0], 1'b1};
    logic [PM_W:0] c0, c1;

    assign c0          = add_metric(pm_q[P0], branch_metric(dec_d_in, P0, Ns[1]));
    assign c1          = add_metric(pm_q[P1], branch_metric(dec_d_in, P1, Ns[1]));
    assign sel1[g]     = c1 < c0;
    assign sum[g]      = sel1[g] ? c1 : c0;
    assign surv_new[g] = {sel1[g] ? surv_q[P1][TB_LEN-2:0] : surv_q[P0][TB_LEN-2:0], Ns[1]};
  end

  always_comb begin
    best    = 2'd0;
    min_sum = sum[0];
    for (int i = 1; i < 4; i++) begin
      if (sum[i] < min_sum) begin
        min_sum = sum[i];
        best    = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
`ifdef ENCODER_DECODER_PM_NORM_EN
      pm_d[i] = PM_W'(sum[i] - min_sum);
`else
      pm_d[i] = sum[i][PM_W-1:0];
`endif
    end
  end

  assign cnt_inc  = {1'b0, cnt_q} + (CntW + 1)'(1);
  assign cnt_full = cnt_inc >= (CntW + 1)'(TB_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(16);
        surv_q[i] <= '0;
      end
      cnt_q       <= '0;
      dec_d_out   <= 1'b0;
      dec_valid_o <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_new[i];
      end
      cnt_q       <= cnt_full ? CntW'(TB_LEN) : cnt_inc[CntW-1:0];
      dec_d_out   <= surv_new[best][TB_LEN-1];
      dec_valid_o <= cnt_full;
    end else begin
      dec_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_decoder.sv
// Directed bench for encoder_decoder: encoder vector table, then loopback decode runs
// (clean, sparse errors, enable gaps, mid-stream reset, all-zero metric check).
module tb_encoder_decoder;

  localparam int unsigned TB_LEN = 8;
  localparam int unsigned PM_W   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       dec_d_out;
  logic       dec_valid_o;

  encoder_decoder #(.TB_LEN(TB_LEN), .PM_W(PM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_enable_i(enc_enable_i),
    .enc_d_in    (enc_d_in),
    .enc_valid_o (enc_valid_o),
    .enc_d_out   (enc_d_out),
    .dec_enable  (dec_enable),
    .dec_d_in    (dec_d_in),
    .dec_d_out   (dec_d_out),
    .dec_valid_o (dec_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       d;
    logic       val;
    logic [1:0] out;
  } enc_vec_t;

  enc_vec_t   ev [8];
  logic       bits [512];
  logic [1:0] syms [512];

  task automatic check_reset_state(input string tag);
    check({tag, "_enc_valid"}, 32'(enc_valid_o), 0);
    check({tag, "_enc_out"}, 32'(enc_d_out), 0);
    check({tag, "_dec_out"}, 32'(dec_d_out), 0);
    check({tag, "_dec_valid"}, 32'(dec_valid_o), 0);
    check({tag, "_pm0"}, 32'(dut.pm_q[0]), 0);
    for (int i = 1; i < 4; i++) check({tag, "_pm"}, 32'(dut.pm_q[i]), 16);
    for (int i = 0; i < 4; i++) check({tag, "_surv"}, 32'(dut.surv_q[i]), 0);
  endtask

  task automatic do_reset();
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // Drives both paths from a model-encoded bit stream and checks every cycle.
  task automatic run(input int n, input int err_per, input int gap_pct, input int stop_at,
                     input bit zeros, input bit regen);
    int ei = 0, di = 0, cyc = 0;
    logic [1:0] s = 2'b00;
    logic [1:0] exp_enc = 2'b00;
    logic [1:0] rx;
    logic exp_dec = 1'b0;
    bit have_dec = 0;
    bit ee, de, ev_ok;
    if (regen) begin
      for (int i = 0; i < n; i++) begin
        bits[i] = zeros ? 1'b0 : 1'($urandom_range(0, 1));
        syms[i] = {bits[i] ^ s[1] ^ s[0], bits[i] ^ s[0]};
        s = {bits[i], s[1]};
      end
    end
    while ((ei < n || di < n) && cyc < 10 * n + 50) begin
      ee = (ei < n) && ($urandom_range(0, 99) >= gap_pct);
      de = (di < n) && ($urandom_range(0, 99) >= gap_pct);
      enc_enable_i = ee;
      enc_d_in     = ee ? bits[ei] : 1'($urandom);
      rx = syms[di < n ? di : 0];
      if (err_per > 0 && (di % err_per) == 10) rx[0] = ~rx[0];
      dec_enable = de;
      dec_d_in   = de ? rx : 2'($urandom);
      if (cyc == stop_at) begin
        #2 rst = 1'b0;
        #1 check_reset_state("midreset");
        enc_enable_i = 1'b0;
        dec_enable   = 1'b0;
        @(posedge clk);
        #1 check_reset_state("midreset_hold");
        #2 rst = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      check("enc_valid", 32'(enc_valid_o), 32'(ee));
      if (ee) begin
        exp_enc = syms[ei];
        ei++;
      end
      check("enc_out", 32'(enc_d_out), 32'(exp_enc));
      if (de) begin
        ev_ok = di >= int'(TB_LEN) - 1;
        check("dec_valid", 32'(dec_valid_o), 32'(ev_ok));
        if (ev_ok) begin
          exp_dec  = bits[di - (int'(TB_LEN) - 1)];
          have_dec = 1;
          check("dec_out", 32'(dec_d_out), 32'(exp_dec));
        end
`ifdef ENCODER_DECODER_PM_NORM_EN
        check("pm_min_zero", 32'((dut.pm_q[0] == 0) || (dut.pm_q[1] == 0) ||
                                 (dut.pm_q[2] == 0) || (dut.pm_q[3] == 0)), 1);
`endif
        di++;
      end else begin
        check("dec_valid_gap", 32'(dec_valid_o), 0);
        if (have_dec) check("dec_out_hold", 32'(dec_d_out), 32'(exp_dec));
      end
      cyc++;
    end
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;
    check("run_complete", 32'(ei >= n && di >= n), 1);
  endtask

  initial begin
    ev[0] = '{1'b1, 1'b1, 1'b1, 2'b11};
    ev[1] = '{1'b1, 1'b0, 1'b1, 2'b10};
    ev[2] = '{1'b0, 1'b1, 1'b0, 2'b10};
    ev[3] = '{1'b1, 1'b1, 1'b1, 2'b00};
    ev[4] = '{1'b1, 1'b1, 1'b1, 2'b01};
    ev[5] = '{1'b0, 1'b0, 1'b0, 2'b01};
    ev[6] = '{1'b1, 1'b0, 1'b1, 2'b01};
    ev[7] = '{1'b1, 1'b0, 1'b1, 2'b11};

    #12 check_reset_state("reset");
    do_reset();

    // Encoder vector table with gaps that must hold output and state.
    for (int i = 0; i < 8; i++) begin
      enc_enable_i = ev[i].en;
      enc_d_in     = ev[i].d;
      @(posedge clk);
      #1;
      check("enc_tbl_valid", 32'(enc_valid_o), 32'(ev[i].val));
      check("enc_tbl_out", 32'(enc_d_out), 32'(ev[i].out));
    end
    enc_enable_i = 1'b0;

    do_reset();
    run(256, 0, 0, -1, 0, 1);   // clean loopback
    do_reset();
    run(256, 32, 0, -1, 0, 0);  // one flipped bit per 32 symbols, same data
    do_reset();
    run(256, 0, 30, -1, 0, 0);  // random enable gaps, same data
    do_reset();
    run(200, 0, 0, 60, 0, 1);   // reset mid-stream
    run(256, 0, 0, -1, 0, 1);   // restarted stream
    do_reset();
    run(300, 0, 0, -1, 1, 1);   // all-zero stream
    check("zero_pm0", 32'(dut.pm_q[0]), 0);
    check("zero_pm1", 32'(dut.pm_q[1]), 3);
    check("zero_pm2", 32'(dut.pm_q[2]), 2);
    check("zero_pm3", 32'(dut.pm_q[3]), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
